// File: rtl/hack_mux_arb.sv
`default_nettype none
// ============================================================================
// Module   : hack_mux_arb
// Brief    : Registered N-channel valid/ready mux. Fixed-select or round-robin
//            arbitration feeds one output register with full back-pressure.
//            Optional burst lock: define HACK_MUX_ARB_LOCK_EN (adds in_last).
// Revision : 1.0 - initial release
// ============================================================================
module hack_mux_arb #(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
`ifdef HACK_MUX_ARB_LOCK_EN
    input  logic [CHANNELS-1:0]       in_last,
`endif
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam logic [SEL_W:0] C_CHN = (SEL_W+1)'(CHANNELS);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             lock_q, lock_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
    logic             lock_rr_q, lock_rr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;

    logic             w_load;
    logic             w_gnt_vld;
    logic [SEL_W-1:0] w_gnt;
    logic             w_rr_eff;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_words [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_words
        assign w_words[i] = in_data[i*WIDTH +: WIDTH];
    end

`ifdef HACK_MUX_ARB_LOCK_EN
    assign w_last = in_last[w_gnt];
`else
    assign w_last = 1'b1;
`endif

    // A held lock overrides both mode and sel until the last beat is taken.
    assign w_rr_eff = lock_q ? lock_rr_q : mode;
    assign w_load   = !out_valid_q || out_ready;
    assign w_accept = w_load && w_gnt_vld;

    always_comb begin : p_grant
        logic [SEL_W:0] idx;
        idx       = '0;
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        if (lock_q) begin
            w_gnt     = lock_ch_q;
            w_gnt_vld = in_valid[lock_ch_q];
        end else if (!mode) begin
            w_gnt = sel;
            if ({1'b0, sel} < C_CHN) begin
                w_gnt_vld = in_valid[sel];
            end
        end else begin
            // Walk from farthest to nearest so the channel closest to ptr wins.
            for (int k = CHANNELS - 1; k >= 0; k--) begin
                idx = {1'b0, ptr_q} + (SEL_W+1)'(k);
                if (idx >= C_CHN) begin
                    idx = idx - C_CHN;
                end
                if (in_valid[idx[SEL_W-1:0]]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = idx[SEL_W-1:0];
                end
            end
        end
    end

    always_comb begin : p_ready
        in_ready = '0;
        if (w_load && w_gnt_vld && !reset) begin
            in_ready[w_gnt] = 1'b1;
        end
    end

    always_comb begin : p_next
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
        lock_rr_d   = lock_rr_q;
        if (w_accept) begin
            out_data_d  = w_words[w_gnt];
            out_sel_d   = w_gnt;
            out_valid_d = 1'b1;
            if (w_rr_eff && w_last) begin
                ptr_d = (({1'b0, w_gnt} + (SEL_W+1)'(1)) == C_CHN) ? '0 : w_gnt + 1'b1;
            end
`ifdef HACK_MUX_ARB_LOCK_EN
            lock_d    = !w_last;
            lock_ch_d = w_gnt;
            lock_rr_d = w_rr_eff;
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
            lock_rr_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
            lock_rr_q   <= lock_rr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_hack_mux_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_hack_mux_arb
// Brief    : Self-checking bench for hack_mux_arb (4-channel main instance plus
//            a 3-channel instance for out-of-range select).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hack_mux_arb;
    localparam int WIDTH = 16;
    localparam int CH    = 4;
    localparam int SW    = 2;
`ifdef HACK_MUX_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                mode = 1'b0;
    logic [SW-1:0]       sel = '0;
    logic [CH*WIDTH-1:0] in_data = '0;
    logic [CH-1:0]       in_valid = '0;
    logic [CH-1:0]       in_last = '0;
    logic [CH-1:0]       in_ready;
    logic [WIDTH-1:0]    out_data;
    logic [SW-1:0]       out_sel;
    logic                out_valid;
    logic                out_ready = 1'b0;

    logic [1:0]          d3_sel = '0;
    logic [3*WIDTH-1:0]  d3_in_data = {16'h3333, 16'h2222, 16'h1111};
    logic [2:0]          d3_in_valid = 3'b111;
    logic [2:0]          d3_in_ready;
    logic [WIDTH-1:0]    d3_out_data;
    logic [1:0]          d3_out_sel;
    logic                d3_out_valid;
`ifdef HACK_MUX_ARB_LOCK_EN
    logic [2:0]          d3_in_last = 3'b111;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit               m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_sel, m_ptr, m_lock_ch;
    bit               m_lock, m_lock_rr;

    always #5 clk = ~clk;

    hack_mux_arb #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid),
`ifdef HACK_MUX_ARB_LOCK_EN
        .in_last(in_last),
`endif
        .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    hack_mux_arb #(.WIDTH(WIDTH), .CHANNELS(3)) dut3 (
        .clk(clk), .reset(reset), .mode(1'b0), .sel(d3_sel),
        .in_data(d3_in_data), .in_valid(d3_in_valid),
`ifdef HACK_MUX_ARB_LOCK_EN
        .in_last(d3_in_last),
`endif
        .in_ready(d3_in_ready), .out_data(d3_out_data), .out_sel(d3_out_sel),
        .out_valid(d3_out_valid), .out_ready(1'b1)
    );

    function automatic int m_grant();
        if (m_lock) return in_valid[m_lock_ch] ? m_lock_ch : -1;
        if (!mode) return (int'(sel) < CH && in_valid[sel]) ? int'(sel) : -1;
        for (int k = 0; k < CH; k++)
            if (in_valid[(m_ptr + k) % CH]) return (m_ptr + k) % CH;
        return -1;
    endfunction

    function automatic logic [CH-1:0] m_ready();
        int g = m_grant();
        logic [CH-1:0] r = '0;
        if ((!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic void m_update();
        int g = m_grant();
        bit load = !m_valid || out_ready;
        bit last, rr;
        if (load && g >= 0) begin
            last    = !LOCK_EN || in_last[g];
            rr      = m_lock ? m_lock_rr : mode;
            m_data  = in_data[g*WIDTH +: WIDTH];
            m_sel   = g;
            m_valid = 1'b1;
            if (rr && last) m_ptr = (g + 1) % CH;
            if (LOCK_EN) begin
                m_lock    = !last;
                m_lock_ch = g;
                m_lock_rr = rr;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endfunction

    function automatic void m_reset();
        m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
        m_lock = 0; m_lock_ch = 0; m_lock_rr = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
    endtask

    task automatic set_word(input int ch, input logic [WIDTH-1:0] v);
        in_data[ch*WIDTH +: WIDTH] = v;
    endtask

    task automatic test_reset();
        mode = 1'b1; in_valid = '1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 16'h0) begin bad++; $display("FAIL rst_data got=%h want=0000", out_data); end
        total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL rst_sel got=%0d want=0", out_sel); end
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b want=0000", in_ready); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL rst_release_ready got=%b want=0001", in_ready); end
    endtask

    task automatic test_fixed();
        for (int i = 0; i < CH; i++) set_word(i, WIDTH'($urandom));
        set_word(2, 16'h1234);
        set_word(3, 16'h5678);
        mode = 1'b0; sel = 2'd2; in_valid = '1; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL fixed_ready2 got=%b want=0100", in_ready); end
        tick();
        total++; if (out_data !== 16'h1234 || out_sel !== 2'd2 || out_valid !== 1'b1) begin
            bad++; $display("FAIL fixed_out2 got=%h/%0d/%b want=1234/2/1", out_data, out_sel, out_valid); end
        sel = 2'd3;
        #1;
        total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL fixed_ready3 got=%b want=1000", in_ready); end
        tick();
        total++; if (out_data !== 16'h5678 || out_sel !== 2'd3) begin
            bad++; $display("FAIL fixed_out3 got=%h/%0d want=5678/3", out_data, out_sel); end
    endtask

    task automatic test_sel_oob();
        d3_sel = 2'd3;
        #1;
        total++; if (d3_in_ready !== 3'b000) begin bad++; $display("FAIL oob_ready got=%b want=000", d3_in_ready); end
        d3_sel = 2'd2;
        #1;
        total++; if (d3_in_ready !== 3'b100) begin bad++; $display("FAIL oob_inrange_ready got=%b want=100", d3_in_ready); end
        tick();
        total++; if (d3_out_data !== 16'h3333 || d3_out_sel !== 2'd2) begin
            bad++; $display("FAIL oob_out got=%h/%0d want=3333/2", d3_out_data, d3_out_sel); end
    endtask

    task automatic test_rr_fair();
        do_reset();
        for (int i = 0; i < CH; i++) set_word(i, 16'hA000 + 16'(i));
        mode = 1'b1; in_valid = '1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (in_ready !== 4'(1 << (i % 4))) begin
                bad++; $display("FAIL rr_ready beat=%0d got=%b want=%b", i, in_ready, 4'(1 << (i % 4))); end
            tick();
            total++; if (out_sel !== 2'(i % 4) || out_data !== 16'hA000 + 16'(i % 4) || out_valid !== 1'b1) begin
                bad++; $display("FAIL rr_out beat=%0d got=%0d/%h/%b want=%0d/%h/1", i, out_sel, out_data, out_valid,
                                i % 4, 16'hA000 + 16'(i % 4)); end
        end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        #1;
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready got=%b want=0000", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_data !== 16'hA000 || out_sel !== 2'd0 || out_valid !== 1'b1 || in_ready !== 4'b0000) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=%h/%0d/%b/%b want=a000/0/1/0000", i, out_data, out_sel,
                                out_valid, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got=%b want=0010", in_ready); end
        tick();
        total++; if (out_sel !== 2'd1 || out_data !== 16'hA001 || out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_release_out got=%0d/%h/%b want=1/a001/1", out_sel, out_data, out_valid); end
    endtask

    task automatic test_sparse();
        int exp_g[4] = '{3, 1, 3, 1};
        do_reset();
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0010;
        #1;
        total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL sparse_prime got=%b want=0010", in_ready); end
        tick();
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (in_ready !== 4'(1 << exp_g[i])) begin
                bad++; $display("FAIL sparse_ready step=%0d got=%b want=%b", i, in_ready, 4'(1 << exp_g[i])); end
            tick();
            total++; if (out_sel !== 2'(exp_g[i])) begin
                bad++; $display("FAIL sparse_sel step=%0d got=%0d want=%0d", i, out_sel, exp_g[i]); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 63) == 0) begin
                reset = 1'b1;
                #1;
                total++; if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
                    bad++; $display("FAIL rand_midreset got=%b/%b want=0/0000", out_valid, in_ready); end
                @(posedge clk);
                #1;
                reset = 1'b0;
                m_reset();
            end
            if ($urandom_range(0, 7) == 0) mode = 1'($urandom);
            sel       = SW'($urandom);
            in_valid  = CH'($urandom);
            in_last   = CH'($urandom);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            total++; if (in_ready !== m_ready()) begin
                bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, in_ready, m_ready()); end
            tick();
            total++; if (out_valid !== m_valid || out_data !== m_data || out_sel !== SW'(m_sel)) begin
                bad++; $display("FAIL rand_out cyc=%0d got=%b/%h/%0d want=%b/%h/%0d", c, out_valid, out_data,
                                out_sel, m_valid, m_data, m_sel); end
        end
    endtask

`ifdef HACK_MUX_ARB_LOCK_EN
    task automatic test_lock();
        int exp_s[4] = '{0, 0, 0, 1};
        do_reset();
        for (int i = 0; i < CH; i++) set_word(i, 16'hB000 + 16'(i));
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0011;
        for (int b = 0; b < 4; b++) begin
            in_last = {2'b00, 1'b1, (b == 2)};
            mode    = (b == 1) ? 1'b0 : 1'b1;
            sel     = 2'd3;
            #1;
            tick();
            total++; if (out_sel !== 2'(exp_s[b])) begin
                bad++; $display("FAIL lock_sel beat=%0d got=%0d want=%0d", b, out_sel, exp_s[b]); end
        end
        mode = 1'b1; in_valid = 4'b0100; in_last = 4'b0000;
        #1;
        tick();
        reset = 1'b1;
        #2;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
        in_valid = 4'b0101;
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL lock_reset_ready got=%b want=0001", in_ready); end
    endtask
`endif

    initial begin
        m_reset();
        test_reset();
        test_fixed();
        test_sel_oob();
        test_rr_fair();
        test_back_pressure();
        test_sparse();
`ifdef HACK_MUX_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
